msk_and_hpc3_pipe: RTL and testbench

//  W-lane, d-share masked AND (HPC3 structure) with a valid/ready stream interface and a randomness handshake.

---
 rtl/msk_and_hpc3_pipe_if.sv | 48 ++++
 rtl/msk_and_hpc3_pipe.sv | 141 ++++++++++++++
 tb/tb_msk_and_hpc3_pipe.sv | 364 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/msk_and_hpc3_pipe_if.sv
// ---------------------------------------------------------------------------
// msk_and_hpc3_pipe_if
//   Stream bundle for the pipelined masked AND gadget: operand stream,
//   randomness stream and result stream.
//
//   Parameters
//     d : number of shares
//     W : number of parallel AND lanes
//
//   Signals (share k of lane b lives at bit k*W+b of ina/inb/out)
//     in_valid / in_ready   operand handshake
//     ina, inb              operand sharings, W*d bits each
//     rnd_valid / rnd_ready randomness handshake
//     rnd                   fresh randomness, W*d*(d-1) bits
//     out_valid / out_ready result handshake
//     out                   result sharing, W*d bits
//
//   Modports
//     master : producer/consumer side (drives operands, randomness, out_ready)
//     slave  : gadget side
// ---------------------------------------------------------------------------
interface msk_and_hpc3_pipe_if #(
    parameter int d = 2,
    parameter int W = 1
);
    localparam int RND = W * d * (d - 1);

    logic             in_valid;
    logic             in_ready;
    logic [W*d-1:0]   ina;
    logic [W*d-1:0]   inb;
    logic             rnd_valid;
    logic             rnd_ready;
    logic [RND-1:0]   rnd;
    logic             out_valid;
    logic             out_ready;
    logic [W*d-1:0]   out;

    modport master (
        output in_valid, ina, inb, rnd_valid, rnd, out_ready,
        input  in_ready, rnd_ready, out_valid, out
    );

    modport slave (
        input  in_valid, ina, inb, rnd_valid, rnd, out_ready,
        output in_ready, rnd_ready, out_valid, out
    );
endinterface

// File: rtl/msk_and_hpc3_pipe.sv
// ---------------------------------------------------------------------------
// msk_and_hpc3_pipe
//   W-lane, d-share masked AND with HPC3 structure and one register stage.
//   For each share i and each partner j != i the gadget registers
//     u_ij = (~a_i & r0_ij) ^ r1_ij,  v_ij = b_j ^ r0_ij,  ap_i = a_i
//   and (INNER=1) ab_i = a_i & b_i, then forms
//     out_i = XOR_j (u_ij ^ (ap_i & v_ij)) [^ ab_i]
//   purely from registers. All registers share one enable (accept), so a
//   stalled result stays stable and randomness is only used on accepts.
//
//   Parameters
//     d     : number of shares (>= 2)
//     W     : number of AND lanes
//     INNER : 1 adds the a_i&b_i term (full AND), 0 keeps cross terms only
//
//   Ports
//     clk : clock, rising edge
//     rst : synchronous active-high reset
//     bus : msk_and_hpc3_pipe_if.slave stream bundle
// ---------------------------------------------------------------------------
module msk_and_hpc3_pipe #(
    parameter int d     = 2,
    parameter int W     = 1,
    parameter int INNER = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    msk_and_hpc3_pipe_if.slave        bus
);
    // Random bits per lane, and size of each of the r0 / r1 halves.
    localparam int RL = d * (d - 1);
    localparam int NP = RL / 2;

    genvar gi, gs, gk;

    logic           out_valid_q;
    logic           out_valid_d;
    logic           in_ready;
    logic           accept;
    logic [W*d-1:0] out_w;

    // ------------------------------------------------------------------
    // Handshake. in_ready depends only on the output register and the
    // downstream ready, never on in_valid. It is held low while reset is
    // asserted so that neither operands nor randomness are claimed in a
    // reset cycle.
    // ------------------------------------------------------------------
    assign in_ready      = ~rst & (~out_valid_q | bus.out_ready);
    assign accept        = bus.in_valid & bus.rnd_valid & in_ready;

    assign bus.in_ready  = in_ready;
    assign bus.rnd_ready = bus.in_valid & in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out       = out_w;

    always_comb begin
        out_valid_d = out_valid_q;
        if (accept) begin
            out_valid_d = 1'b1;
        end else if (bus.out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
        end
    end

    // ------------------------------------------------------------------
    // Datapath: one block per (lane, share). Partners of share gs are
    // enumerated by slot gk = 0..d-2, skipping gs itself.
    // ------------------------------------------------------------------
    generate
        for (gi = 0; gi < W; gi++) begin : g_lane
            for (gs = 0; gs < d; gs++) begin : g_share
                localparam int SH = gs * W + gi;

                logic         a_s;
                logic         ap_q;
                logic [d-2:0] u_d;
                logic [d-2:0] v_d;
                logic [d-2:0] u_q;
                logic [d-2:0] v_q;
                logic [d-2:0] term;

                assign a_s = bus.ina[SH];

                for (gk = 0; gk < d - 1; gk++) begin : g_pair
                    // Partner share and the unordered pair index shared by
                    // (i,j) and (j,i); both halves of randomness use it.
                    localparam int J  = (gk < gs) ? gk : gk + 1;
                    localparam int LO = (gs < J) ? gs : J;
                    localparam int HI = (gs < J) ? J : gs;
                    localparam int P  = LO * d - (LO * (LO + 1)) / 2 + (HI - 1 - LO);
                    localparam int R0 = gi * RL + P;
                    localparam int R1 = R0 + NP;

                    // u only sees share i, v only sees share j: no share
                    // mixing happens ahead of the registers.
                    assign u_d[gk]  = (~a_s & bus.rnd[R0]) ^ bus.rnd[R1];
                    assign v_d[gk]  = bus.inb[J*W+gi] ^ bus.rnd[R0];
                    // a_i meets b_j only after both are registered.
                    assign term[gk] = u_q[gk] ^ (ap_q & v_q[gk]);
                end

                always_ff @(posedge clk) begin
                    if (rst) begin
                        u_q  <= '0;
                        v_q  <= '0;
                        ap_q <= 1'b0;
                    end else if (accept) begin
                        u_q  <= u_d;
                        v_q  <= v_d;
                        ap_q <= a_s;
                    end
                end

                if (INNER != 0) begin : g_inner
                    logic ab_q;

                    always_ff @(posedge clk) begin
                        if (rst) begin
                            ab_q <= 1'b0;
                        end else if (accept) begin
                            ab_q <= a_s & bus.inb[SH];
                        end
                    end

                    assign out_w[SH] = (^term) ^ ab_q;
                end else begin : g_cross
                    assign out_w[SH] = ^term;
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_msk_and_hpc3_pipe.sv
// ---------------------------------------------------------------------------
// tb_msk_and_hpc3_pipe
//   Three gadget instances:
//     0 : d=2, W=1, INNER=1
//     1 : d=2, W=1, INNER=0
//     2 : d=3, W=8, INNER=1
//   A stream model per instance predicts out_valid, every output share,
//   in_ready and rnd_ready each cycle; a queue of unmasked results checks
//   ordering. Directed sequences add literal expectations.
// ---------------------------------------------------------------------------
module tb_msk_and_hpc3_pipe;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [63:0] ina_v [3];
    logic [63:0] inb_v [3];
    logic [63:0] rnd_v [3];
    logic        in_valid_v  [3];
    logic        rnd_valid_v [3];
    logic        out_ready_v [3];
    logic [63:0] out_o       [3];
    logic        in_ready_o  [3];
    logic        rnd_ready_o [3];
    logic        out_valid_o [3];

    msk_and_hpc3_pipe_if #(.d(2), .W(1)) if0 ();
    msk_and_hpc3_pipe_if #(.d(2), .W(1)) if1 ();
    msk_and_hpc3_pipe_if #(.d(3), .W(8)) if2 ();

    assign if0.in_valid  = in_valid_v[0];
    assign if0.ina       = ina_v[0][1:0];
    assign if0.inb       = inb_v[0][1:0];
    assign if0.rnd_valid = rnd_valid_v[0];
    assign if0.rnd       = rnd_v[0][1:0];
    assign if0.out_ready = out_ready_v[0];
    assign out_o[0]       = {62'd0, if0.out};
    assign in_ready_o[0]  = if0.in_ready;
    assign rnd_ready_o[0] = if0.rnd_ready;
    assign out_valid_o[0] = if0.out_valid;

    assign if1.in_valid  = in_valid_v[1];
    assign if1.ina       = ina_v[1][1:0];
    assign if1.inb       = inb_v[1][1:0];
    assign if1.rnd_valid = rnd_valid_v[1];
    assign if1.rnd       = rnd_v[1][1:0];
    assign if1.out_ready = out_ready_v[1];
    assign out_o[1]       = {62'd0, if1.out};
    assign in_ready_o[1]  = if1.in_ready;
    assign rnd_ready_o[1] = if1.rnd_ready;
    assign out_valid_o[1] = if1.out_valid;

    assign if2.in_valid  = in_valid_v[2];
    assign if2.ina       = ina_v[2][23:0];
    assign if2.inb       = inb_v[2][23:0];
    assign if2.rnd_valid = rnd_valid_v[2];
    assign if2.rnd       = rnd_v[2][47:0];
    assign if2.out_ready = out_ready_v[2];
    assign out_o[2]       = {40'd0, if2.out};
    assign in_ready_o[2]  = if2.in_ready;
    assign rnd_ready_o[2] = if2.rnd_ready;
    assign out_valid_o[2] = if2.out_valid;

    msk_and_hpc3_pipe #(.d(2), .W(1), .INNER(1)) dut0 (.clk(clk), .rst(rst), .bus(if0));
    msk_and_hpc3_pipe #(.d(2), .W(1), .INNER(0)) dut1 (.clk(clk), .rst(rst), .bus(if1));
    msk_and_hpc3_pipe #(.d(3), .W(8), .INNER(1)) dut2 (.clk(clk), .rst(rst), .bus(if2));

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 40)
                $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- instance configuration ----------------
    function automatic int pd(input int k);
        return (k == 2) ? 3 : 2;
    endfunction
    function automatic int pw(input int k);
        return (k == 2) ? 8 : 1;
    endfunction
    function automatic int pin(input int k);
        return (k == 1) ? 0 : 1;
    endfunction

    // Every output share from the algebra of the gadget: the r0 terms cancel
    // inside each pair, leaving r0^r1^a_i*b_j per partner plus the inner term.
    function automatic logic [63:0] model_out(input int k, input logic [63:0] a,
                                              input logic [63:0] b, input logic [63:0] r);
        int dd, ww, np, lo, hi, p, base;
        logic [63:0] o;
        logic s;
        dd = pd(k);
        ww = pw(k);
        np = dd * (dd - 1) / 2;
        o  = '0;
        for (int l = 0; l < ww; l++) begin
            for (int i = 0; i < dd; i++) begin
                s = (pin(k) != 0) ? (a[i*ww+l] & b[i*ww+l]) : 1'b0;
                for (int j = 0; j < dd; j++) begin
                    if (j != i) begin
                        lo   = (i < j) ? i : j;
                        hi   = (i < j) ? j : i;
                        p    = lo * dd - lo * (lo + 1) / 2 + hi - 1 - lo;
                        base = l * dd * (dd - 1);
                        s    = s ^ r[base+p] ^ r[base+np+p] ^ (a[i*ww+l] & b[j*ww+l]);
                    end
                end
                o[i*ww+l] = s;
            end
        end
        return o;
    endfunction

    function automatic logic [7:0] unmask(input int k, input logic [63:0] v);
        logic [7:0] res;
        res = '0;
        for (int l = 0; l < pw(k); l++)
            for (int i = 0; i < pd(k); i++)
                res[l] = res[l] ^ v[i*pw(k)+l];
        return res;
    endfunction

    // Unmasked result: a&b per lane, or only the cross products when INNER=0.
    function automatic logic [7:0] plain(input int k, input logic [63:0] a, input logic [63:0] b);
        logic [7:0] res;
        res = unmask(k, a) & unmask(k, b);
        if (pin(k) == 0)
            for (int l = 0; l < pw(k); l++)
                for (int i = 0; i < pd(k); i++)
                    res[l] = res[l] ^ (a[i*pw(k)+l] & b[i*pw(k)+l]);
        return res;
    endfunction

    // ---------------- stream model and compare process ----------------
    logic        mon_en = 1'b0;
    logic        m_valid [3];
    logic [63:0] m_out   [3];
    logic [7:0]  exp_q   [3][$];
    int          acc_cnt [3];
    int          rnd_cnt [3];
    int          xfer_cnt[3];

    task automatic mon(input int k);
        logic exp_rdy;
        logic acc;
        logic [7:0] front;
        chk($sformatf("i%0d out_valid", k), 64'(out_valid_o[k]), 64'(m_valid[k]));
        chk($sformatf("i%0d out", k), out_o[k], m_out[k]);
        acc = 1'b0;
        if (!rst) begin
            exp_rdy = !m_valid[k] || out_ready_v[k];
            chk($sformatf("i%0d in_ready", k), 64'(in_ready_o[k]), 64'(exp_rdy));
            chk($sformatf("i%0d rnd_ready", k), 64'(rnd_ready_o[k]), 64'(in_valid_v[k] & exp_rdy));
            acc = in_valid_v[k] && rnd_valid_v[k] && exp_rdy;
            if (m_valid[k] && out_ready_v[k] && exp_q[k].size() > 0) begin
                front = exp_q[k].pop_front();
                chk($sformatf("i%0d order", k), 64'(unmask(k, out_o[k])), 64'(front));
                xfer_cnt[k]++;
            end
            if (rnd_valid_v[k] && rnd_ready_o[k]) rnd_cnt[k]++;
        end
        if (rst) begin
            m_valid[k] = 1'b0;
            m_out[k]   = '0;
            exp_q[k].delete();
        end else if (acc) begin
            m_valid[k] = 1'b1;
            m_out[k]   = model_out(k, ina_v[k], inb_v[k], rnd_v[k]);
            exp_q[k].push_back(plain(k, ina_v[k], inb_v[k]));
            acc_cnt[k]++;
        end else if (out_ready_v[k]) begin
            m_valid[k] = 1'b0;
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            for (int k = 0; k < 3; k++) mon(k);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int k, input logic iv, input logic rv, input logic orr,
                         input logic [63:0] a, input logic [63:0] b, input logic [63:0] r);
        in_valid_v[k]  = iv;
        rnd_valid_v[k] = rv;
        out_ready_v[k] = orr;
        ina_v[k] = a;
        inb_v[k] = b;
        rnd_v[k] = r;
    endtask

    // One isolated operation on instance k, result checked one cycle later.
    task automatic op_chk(input int k, input logic [63:0] a, input logic [63:0] b,
                          input logic [63:0] r, input logic [7:0] exp_plain, input string tag);
        tick();
        drive(k, 1'b1, 1'b1, 1'b1, a, b, r);
        @(negedge clk);
        chk({tag, " ready"}, 64'(in_ready_o[k]), 64'd1);
        tick();
        in_valid_v[k]  = 1'b0;
        rnd_valid_v[k] = 1'b0;
        @(negedge clk);
        chk({tag, " latency"}, 64'(out_valid_o[k]), 64'd1);
        chk({tag, " xor"}, 64'(unmask(k, out_o[k])), 64'(exp_plain));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        errors++;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] a2, b2;
        int n, cyc, a0, r0, x0;
        logic was_acc;

        for (int k = 0; k < 3; k++) begin
            drive(k, 1'b0, 1'b0, 1'b1, '0, '0, '0);
            m_valid[k] = 1'b0;
            m_out[k]   = '0;
            acc_cnt[k] = 0;
            rnd_cnt[k] = 0;
            xfer_cnt[k] = 0;
        end
        rst = 1'b1;
        tick();
        mon_en = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("reset in_ready i%0d", k), 64'(in_ready_o[k]), 64'd1);
            chk($sformatf("reset out_valid i%0d", k), 64'(out_valid_o[k]), 64'd0);
            chk($sformatf("reset out i%0d", k), out_o[k], 64'd0);
        end

        // Test 1: all 16 share combinations, rnd = 2'b11.
        for (int v = 0; v < 16; v++) begin
            a2 = v[1:0];
            b2 = v[3:2];
            op_chk(0, 64'(a2), 64'(b2), 64'd3, 8'((a2[0] ^ a2[1]) & (b2[0] ^ b2[1])), "t1");
        end

        // Test 2: a=(1,0), b=(1,0), r0=1, r1=0.
        op_chk(0, 64'd1, 64'd1, 64'd1, 8'd1, "t2 inner");
        chk("t2 inner shares", out_o[0], 64'b10);
        op_chk(1, 64'd1, 64'd1, 64'd1, 8'd0, "t2 cross");
        chk("t2 cross shares", out_o[1], 64'b11);

        // Test 3: backpressure, then simultaneous drain and accept.
        tick();
        drive(0, 1'b1, 1'b1, 1'b0, 64'b11, 64'b10, 64'b11);
        @(negedge clk);
        for (int c = 0; c < 5; c++) begin
            tick();
            drive(0, 1'b1, 1'b1, 1'b0, 64'd0, 64'd0, 64'd0);
            @(negedge clk);
            chk("t3 held out", out_o[0], 64'b11);
            chk("t3 held valid", 64'(out_valid_o[0]), 64'd1);
            chk("t3 in_ready", 64'(in_ready_o[0]), 64'd0);
            chk("t3 rnd_ready", 64'(rnd_ready_o[0]), 64'd0);
        end
        tick();
        out_ready_v[0] = 1'b1;
        @(negedge clk);
        chk("t3 swap ready", 64'(in_ready_o[0]), 64'd1);
        tick();
        in_valid_v[0]  = 1'b0;
        rnd_valid_v[0] = 1'b0;
        @(negedge clk);
        chk("t3 swap valid", 64'(out_valid_o[0]), 64'd1);
        chk("t3 swap out", out_o[0], 64'd0);

        // Test 4: randomness not available for three cycles.
        tick();
        drive(0, 1'b1, 1'b0, 1'b1, 64'b01, 64'b01, 64'b01);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("t4 no out", 64'(out_valid_o[0]), 64'd0);
            chk("t4 in_ready", 64'(in_ready_o[0]), 64'd1);
            tick();
        end
        rnd_valid_v[0] = 1'b1;
        @(negedge clk);
        chk("t4 accept", 64'(in_ready_o[0] & rnd_valid_v[0]), 64'd1);
        tick();
        in_valid_v[0]  = 1'b0;
        rnd_valid_v[0] = 1'b0;
        @(negedge clk);
        chk("t4 valid", 64'(out_valid_o[0]), 64'd1);
        chk("t4 out", out_o[0], 64'b10);

        // Test 5: reset while a result is stalled.
        tick();
        drive(0, 1'b1, 1'b1, 1'b0, 64'b11, 64'b10, 64'b11);
        @(negedge clk);
        tick();
        rst = 1'b1;
        @(negedge clk);
        chk("t5 pending", 64'(out_valid_o[0]), 64'd1);
        tick();
        rst = 1'b0;
        in_valid_v[0]  = 1'b0;
        rnd_valid_v[0] = 1'b0;
        @(negedge clk);
        chk("t5 valid cleared", 64'(out_valid_o[0]), 64'd0);
        chk("t5 out cleared", out_o[0], 64'd0);
        out_ready_v[0] = 1'b1;
        tick();
        @(negedge clk);
        chk("t5 not re-emitted", 64'(out_valid_o[0]), 64'd0);

        // Test 6: d=3, W=8 random traffic with stalls on both sides.
        a0 = acc_cnt[2];
        r0 = rnd_cnt[2];
        x0 = xfer_cnt[2];
        n = 0;
        cyc = 0;
        was_acc = 1'b0;
        while (n < 1000 && cyc < 20000) begin
            tick();
            if (!in_valid_v[2] || was_acc) begin
                in_valid_v[2] = ($urandom_range(0, 3) != 0);
                ina_v[2] = {40'd0, 24'($urandom)};
                inb_v[2] = {40'd0, 24'($urandom)};
            end
            rnd_valid_v[2] = ($urandom_range(0, 3) != 0);
            rnd_v[2] = {16'd0, 16'($urandom), 32'($urandom)};
            out_ready_v[2] = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            was_acc = in_valid_v[2] & rnd_valid_v[2] & in_ready_o[2];
            if (was_acc) n++;
            cyc++;
        end
        chk("t6 accepts", 64'(n), 64'd1000);
        tick();
        drive(2, 1'b0, 1'b0, 1'b1, '0, '0, '0);
        tick();
        @(negedge clk);
        chk("t6 model accepts", 64'(acc_cnt[2] - a0), 64'(n));
        chk("t6 results out", 64'(xfer_cnt[2] - x0), 64'(n));
        chk("t6 rnd consumed", 64'(rnd_cnt[2] - r0), 64'(n));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
